pet_needs_engine: RTL

// Parametrised needs/health engine for the virtual-pet core. Holds NUM_NEEDS need levels

---
 rtl/pet_needs_engine.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pet_needs_engine.sv
// Needs/health engine for the virtual-pet core: per-need decay on independent periods,
// user actions and heal, health drain while starving, test-mode level editing, face code.
module pet_needs_engine #(
  parameter int unsigned NUM_NEEDS     = 4,
  parameter int unsigned LEVEL_W       = 3,
  parameter int unsigned LEVEL_MAX     = 5,
  parameter int unsigned WARN_LEVEL    = 3,
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned PER_W         = 7,
  parameter logic [NUM_NEEDS*PER_W-1:0] DECAY_PERIODS = {4{7'd30}},
  parameter int unsigned HEALTH_PERIOD = 10,
  parameter int unsigned FLASH_CYCLES  = 5000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_NEEDS-1:0]           action,
  input  logic                           heal,
  input  logic                           test_tog,
  input  logic                           test_next,
  input  logic                           test_inc,
  input  logic                           test_dec,
  output logic [NUM_NEEDS*LEVEL_W-1:0]   levels,
  output logic [LEVEL_W-1:0]             health,
  output logic                           dead,
  output logic                           test_mode,
  output logic [2:0]                     test_sel,
  output logic [3:0]                     face,
  output logic                           sec_tick
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HC_W  = (HEALTH_PERIOD > 1) ? $clog2(HEALTH_PERIOD) : 1;
  localparam int unsigned FL_W  = $clog2(FLASH_CYCLES + 1);
  localparam int unsigned SEL_W = 3;
  localparam logic [LEVEL_W-1:0] LMAX  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LWARN = LEVEL_W'(WARN_LEVEL);

  function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] v);
    return (v >= LMAX) ? LMAX : v + LEVEL_W'(1);
  endfunction

  function automatic logic [LEVEL_W-1:0] sat_dec(input logic [LEVEL_W-1:0] v);
    return (v == '0) ? '0 : v - LEVEL_W'(1);
  endfunction

  logic [PRE_W-1:0]     presc_q, presc_d;
  logic                 tick_q, tick_d;
  logic [LEVEL_W-1:0]   lvl_q [NUM_NEEDS];
  logic [LEVEL_W-1:0]   lvl_d [NUM_NEEDS];
  logic [PER_W-1:0]     dcnt_q [NUM_NEEDS];
  logic [PER_W-1:0]     dcnt_d [NUM_NEEDS];
  logic [LEVEL_W-1:0]   health_q, health_d;
  logic [HC_W-1:0]      hcnt_q, hcnt_d;
  logic                 dead_q, dead_d;
  logic                 tmode_q, tmode_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [3:0]           face_q, face_d;
  logic [3:0]           flash_code_q, flash_code_d;
  logic [FL_W-1:0]      flash_cnt_q, flash_cnt_d;
  logic [NUM_NEEDS-1:0] act_prev_q;
  logic [4:0]           btn_prev_q;
  logic [NUM_NEEDS-1:0] act_e;
  logic [4:0]           btn_e;
  logic                 live, run, starving, any_low, any_warn;

  // Button order in btn_*: heal, test_tog, test_next, test_inc, test_dec
  always_comb begin
    act_e        = action & ~act_prev_q;
    btn_e        = {heal, test_tog, test_next, test_inc, test_dec} & ~btn_prev_q;
    live         = !dead_q;
    run          = live && !tmode_q;
    tick_d       = (presc_q == PRE_W'(TICK_DIV - 1));
    presc_d      = tick_d ? '0 : presc_q + PRE_W'(1);
    lvl_d        = lvl_q;
    dcnt_d       = dcnt_q;
    health_d     = health_q;
    hcnt_d       = hcnt_q;
    tmode_d      = tmode_q;
    sel_d        = sel_q;
    flash_code_d = flash_code_q;
    flash_cnt_d  = (flash_cnt_q != '0) ? flash_cnt_q - FL_W'(1) : '0;
    starving     = 1'b0;
    any_low      = (health_q < LWARN);
    any_warn     = (health_q == LWARN);
    for (int i = 0; i < int'(NUM_NEEDS); i++) begin
      if (lvl_q[i] == '0) starving = 1'b1;
      if (lvl_q[i] < LWARN) any_low = 1'b1;
      if (lvl_q[i] == LWARN) any_warn = 1'b1;
    end

    // Per-need decay; an action on the same channel below overrides it
    if (run && tick_q) begin
      for (int i = 0; i < int'(NUM_NEEDS); i++) begin
        if (dcnt_q[i] == DECAY_PERIODS[i*PER_W +: PER_W] - PER_W'(1)) begin
          dcnt_d[i] = '0;
          lvl_d[i]  = sat_dec(lvl_q[i]);
        end else begin
          dcnt_d[i] = dcnt_q[i] + PER_W'(1);
        end
      end
    end

    if (run) begin
      if (!starving) begin
        hcnt_d = '0;
      end else if (tick_q) begin
        if (hcnt_q == HC_W'(HEALTH_PERIOD - 1)) begin
          hcnt_d   = '0;
          health_d = sat_dec(health_q);
        end else begin
          hcnt_d = hcnt_q + HC_W'(1);
        end
      end
    end

    if (live && btn_e[4]) begin
      hcnt_d       = '0;
      health_d     = sat_inc(health_q);
      flash_cnt_d  = FL_W'(FLASH_CYCLES);
      flash_code_d = 4'hC;
    end

    if (run && (act_e != '0)) begin
      flash_cnt_d = FL_W'(FLASH_CYCLES);
      for (int i = int'(NUM_NEEDS) - 1; i >= 0; i--) begin
        if (act_e[i]) begin
          dcnt_d[i]    = '0;
          lvl_d[i]     = sat_inc(lvl_q[i]);
          flash_code_d = 4'(i + 1);
        end
      end
    end

    // Test-mode editing; inc and dec together cancel
    if (live) begin
      if (btn_e[3]) tmode_d = !tmode_q;
      if (tmode_q) begin
        if (btn_e[2]) sel_d = (sel_q == SEL_W'(NUM_NEEDS)) ? '0 : sel_q + SEL_W'(1);
        if (btn_e[1] != btn_e[0]) begin
          if (sel_q == SEL_W'(NUM_NEEDS)) begin
            health_d = btn_e[1] ? sat_inc(health_q) : sat_dec(health_q);
          end
          for (int i = 0; i < int'(NUM_NEEDS); i++) begin
            if (sel_q == SEL_W'(i)) lvl_d[i] = btn_e[1] ? sat_inc(lvl_q[i]) : sat_dec(lvl_q[i]);
          end
        end
      end
    end

    dead_d = dead_q || (health_q == '0);
    if (dead_d) begin
      health_d = '0;
      for (int i = 0; i < int'(NUM_NEEDS); i++) lvl_d[i] = '0;
    end

    if (dead_q)                 face_d = 4'hB;
    else if (tmode_q)           face_d = 4'h7;
    else if (flash_cnt_q != '0) face_d = flash_code_q;
    else if (any_low)           face_d = 4'hA;
    else if (any_warn)          face_d = 4'h9;
    else                        face_d = 4'h8;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      tick_q       <= 1'b0;
      health_q     <= LMAX;
      hcnt_q       <= '0;
      dead_q       <= 1'b0;
      tmode_q      <= 1'b0;
      sel_q        <= '0;
      face_q       <= 4'h8;
      flash_code_q <= '0;
      flash_cnt_q  <= '0;
      act_prev_q   <= '0;
      btn_prev_q   <= '0;
      for (int i = 0; i < int'(NUM_NEEDS); i++) begin
        lvl_q[i]  <= LMAX;
        dcnt_q[i] <= '0;
      end
    end else begin
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      health_q     <= health_d;
      hcnt_q       <= hcnt_d;
      dead_q       <= dead_d;
      tmode_q      <= tmode_d;
      sel_q        <= sel_d;
      face_q       <= face_d;
      flash_code_q <= flash_code_d;
      flash_cnt_q  <= flash_cnt_d;
      act_prev_q   <= action;
      btn_prev_q   <= {heal, test_tog, test_next, test_inc, test_dec};
      lvl_q        <= lvl_d;
      dcnt_q       <= dcnt_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_NEEDS); g++) begin : g_levels
    assign levels[g*LEVEL_W +: LEVEL_W] = lvl_q[g];
  end

  assign health    = health_q;
  assign dead      = dead_q;
  assign test_mode = tmode_q;
  assign test_sel  = sel_q;
  assign face      = face_q;
  assign sec_tick  = tick_q;

endmodule
